// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions for the memory-access stage:
// funct3 codes, MEM-stage FSM encodings and the MEM/WB register layout.
package rv32_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic        reg_write;
        logic [2:0]  result_src;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] imm_ext;
        logic [31:0] pc_target;
        logic [31:0] pc4;
    } mem_wb_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational load/store lane handling: byte enables, store lane
// replication, load byte/half extraction with sign/zero extension, misalign.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        byte_sh   = load_word >> {addr_lo, 3'b000};
        half_sh   = load_word >> {addr_lo[1], 4'b0000};
        be        = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
        misalign  = ((mode[1:0] == 2'b01) && addr_lo[0]) ||
                    ((mode[1:0] == 2'b10) && (addr_lo != 2'b00));

        // Reserved codes fall through to full-word lanes and LW semantics.
        case (mode)
            LB, LBU: begin
                be        = 4'b0001 << addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = mode[2] ? {24'b0, byte_sh[7:0]}
                                    : {{24{byte_sh[7]}}, byte_sh[7:0]};
            end
            LH, LHU: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata     = {2{store_data[15:0]}};
                load_data = mode[2] ? {16'b0, half_sh[15:0]}
                                    : {{16{half_sh[15]}}, half_sh[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: req/ack data-memory master with wait-state
// stall and optional timeout, plus the MEM/WB pipeline register.
module mem_stage
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite_M,
    input  logic              memWrite_M,
    input  logic              memRead_M,
    input  logic [2:0]        resultScr_M,
    input  logic [2:0]        mode_M,
    input  logic [4:0]        rd_M,
    input  logic [31:0]       ALURuslt_M,
    input  logic [31:0]       write_Data_M,
    input  logic [31:0]       imm_extended_M,
    input  logic [31:0]       PC_target_mux_M,
    input  logic [31:0]       pc4_M,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_M,
    output logic              misalign_M,
    output logic              bus_err_M,
    output logic              regWrite_W,
    output logic [2:0]        resultScr_W,
    output logic [4:0]        rd_W,
    output logic [31:0]       ALUResult_W,
    output logic [31:0]       ReadData_W,
    output logic [31:0]       imm_extended_W,
    output logic [31:0]       PC_target_W,
    output logic [31:0]       pc4_W
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_wb_t          wb_q, wb_d;
    mem_wb_t          m_pass;
    logic             access;
    logic             misalign;
    logic [31:0]      load_data;
    logic             tmo_hit;

    lsu_align u_lsu_align (
        .mode       (mode_M),
        .addr_lo    (ALURuslt_M[1:0]),
        .store_data (write_Data_M),
        .load_word  (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign access    = memRead_M | memWrite_M;
    assign dmem_we   = memWrite_M;
    assign dmem_addr = {ALURuslt_M[ADDR_W-1:2], 2'b00};
    assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        m_pass            = '0;
        m_pass.reg_write  = regWrite_M;
        m_pass.result_src = resultScr_M;
        m_pass.rd         = rd_M;
        m_pass.alu_result = ALURuslt_M;
        m_pass.imm_ext    = imm_extended_M;
        m_pass.pc_target  = PC_target_mux_M;
        m_pass.pc4        = pc4_M;
    end

    // Outputs are gated by rst so an in-flight request drops immediately.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_d       = '0;
        dmem_req   = 1'b0;
        stall_M    = 1'b0;
        misalign_M = 1'b0;
        bus_err_M  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (!access) begin
                        wb_d = m_pass;
                    end else if (misalign) begin
                        misalign_M = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        if (dmem_ack) begin
                            wb_d           = m_pass;
                            wb_d.read_data = load_data;
                        end else begin
                            stall_M = 1'b1;
                            cnt_d   = '0;
                            state_d = WAIT;
                        end
                    end
                end
                default: begin
                    dmem_req = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (dmem_ack) begin
                        wb_d           = m_pass;
                        wb_d.read_data = load_data;
                        state_d        = IDLE;
                    end else if (tmo_hit) begin
                        bus_err_M = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stall_M = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wb_q    <= wb_d;
        end
    end

    assign regWrite_W     = wb_q.reg_write;
    assign resultScr_W    = wb_q.result_src;
    assign rd_W           = wb_q.rd;
    assign ALUResult_W    = wb_q.alu_result;
    assign ReadData_W     = wb_q.read_data;
    assign imm_extended_W = wb_q.imm_ext;
    assign PC_target_W    = wb_q.pc_target;
    assign pc4_W          = wb_q.pc4;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expectations into a
// queue, a monitor checks bus/stall outputs mid-cycle and MEM/WB after the edge.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        regWrite_M, memWrite_M, memRead_M;
    logic [2:0]  resultScr_M, mode_M;
    logic [4:0]  rd_M;
    logic [31:0] ALURuslt_M, write_Data_M, imm_extended_M, PC_target_mux_M, pc4_M;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall_M, misalign_M, bus_err_M;
    logic        regWrite_W;
    logic [2:0]  resultScr_W;
    logic [4:0]  rd_W;
    logic [31:0] ALUResult_W, ReadData_W, imm_extended_W, PC_target_W, pc4_W;

    mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .regWrite_M(regWrite_M), .memWrite_M(memWrite_M), .memRead_M(memRead_M),
        .resultScr_M(resultScr_M), .mode_M(mode_M), .rd_M(rd_M),
        .ALURuslt_M(ALURuslt_M), .write_Data_M(write_Data_M),
        .imm_extended_M(imm_extended_M), .PC_target_mux_M(PC_target_mux_M), .pc4_M(pc4_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_M(stall_M), .misalign_M(misalign_M), .bus_err_M(bus_err_M),
        .regWrite_W(regWrite_W), .resultScr_W(resultScr_W), .rd_W(rd_W),
        .ALUResult_W(ALUResult_W), .ReadData_W(ReadData_W),
        .imm_extended_W(imm_extended_W), .PC_target_W(PC_target_W), .pc4_W(pc4_W)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         req;
        logic         we;
        logic [31:0]  addr;
        logic [3:0]   be;
        logic [31:0]  wdata;
        logic         stall;
        logic         mis;
        logic         berr;
        logic         wnow0;
        logic [168:0] w;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [168:0] act, input logic [168:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [168:0] w_now();
        return {regWrite_W, resultScr_W, rd_W, ALUResult_W, ReadData_W,
                imm_extended_W, PC_target_W, pc4_W};
    endfunction

    function automatic logic [168:0] pass_w(input logic [31:0] rdv);
        return {regWrite_M, resultScr_M, rd_M, ALURuslt_M, rdv,
                imm_extended_M, PC_target_mux_M, pc4_M};
    endfunction

    function automatic exp_t mk(input logic req, input logic stall, input logic mis,
                                input logic berr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [168:0] w);
        exp_t e;
        e.req   = req;
        e.we    = memWrite_M;
        e.addr  = {ALURuslt_M[31:2], 2'b00};
        e.be    = be;
        e.wdata = wdata;
        e.stall = stall;
        e.mis   = mis;
        e.berr  = berr;
        e.wnow0 = 1'b0;
        e.w     = w;
        return e;
    endfunction

    task automatic setm(input logic rw, input logic mw, input logic mr, input logic [2:0] md,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rdat);
        regWrite_M      = rw;
        memWrite_M      = mw;
        memRead_M       = mr;
        mode_M          = md;
        rd_M            = rd;
        ALURuslt_M      = a;
        write_Data_M    = wd;
        resultScr_M     = 3'b001;
        imm_extended_M  = 32'h1111_0000 | {27'b0, rd};
        PC_target_mux_M = 32'h2000_0000 + a;
        pc4_M           = 32'h4000_0004 + {27'b0, rd};
        dmem_ack        = ack;
        dmem_rdata      = rdat;
    endtask

    task automatic step(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: bus/status outputs mid-cycle, MEM/WB one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("dmem_req", 169'(dmem_req), 169'(e.req));
                chk("stall_M", 169'(stall_M), 169'(e.stall));
                chk("misalign_M", 169'(misalign_M), 169'(e.mis));
                chk("bus_err_M", 169'(bus_err_M), 169'(e.berr));
                if (e.req) begin
                    chk("dmem_we", 169'(dmem_we), 169'(e.we));
                    chk("dmem_addr", 169'(dmem_addr), 169'(e.addr));
                    chk("dmem_be", 169'(dmem_be), 169'(e.be));
                    chk("dmem_wdata", 169'(dmem_wdata), 169'(e.wdata));
                end
                if (e.wnow0) chk("w_async_reset", w_now(), '0);
                @(posedge clk);
                #1;
                chk("mem_wb", w_now(), e.w);
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        setm(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        @(posedge clk);
        #2;
        // reset state
        step(mk(0, 0, 0, 0, 4'b0000, 32'h0, '0));
        rst = 1'b0;

        // no access: pass-through, ReadData 0
        setm(1, 0, 0, 3'b000, 5'd7, 32'h0000_0055, 32'h0, 0, 32'h1234_5678);
        step(mk(0, 0, 0, 0, 4'b0000, 32'h0, pass_w(32'h0)));

        // LW zero-wait
        setm(1, 0, 1, 3'b010, 5'd5, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF);
        step(mk(1, 0, 0, 0, 4'b1111, 32'h0, pass_w(32'hDEAD_BEEF)));

        // LB / LBU at 0x103
        setm(1, 0, 1, 3'b000, 5'd6, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
        step(mk(1, 0, 0, 0, 4'b1000, 32'h0, pass_w(32'hFFFF_FF80)));
        setm(1, 0, 1, 3'b100, 5'd6, 32'h0000_0103, 32'h0, 1, 32'h8012_3456);
        step(mk(1, 0, 0, 0, 4'b1000, 32'h0, pass_w(32'h0000_0080)));

        // LH 0x102 sign, LHU 0x100 zero
        setm(1, 0, 1, 3'b001, 5'd8, 32'h0000_0102, 32'h0, 1, 32'h8001_1234);
        step(mk(1, 0, 0, 0, 4'b1100, 32'h0, pass_w(32'hFFFF_8001)));
        setm(1, 0, 1, 3'b101, 5'd8, 32'h0000_0100, 32'h0, 1, 32'h1234_F00D);
        step(mk(1, 0, 0, 0, 4'b0011, 32'h0, pass_w(32'h0000_F00D)));

        // SH 0x102 with three wait cycles
        setm(0, 1, 0, 3'b001, 5'd0, 32'h0000_0102, 32'h1234_ABCD, 0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(mk(1, 1, 0, 0, 4'b1100, 32'hABCD_ABCD, '0));
        dmem_ack = 1'b1;
        step(mk(1, 0, 0, 0, 4'b1100, 32'hABCD_ABCD, pass_w(32'h0)));

        // SB 0x101 zero-wait
        setm(0, 1, 0, 3'b000, 5'd0, 32'h0000_0101, 32'h0000_00A5, 1, 32'h0);
        step(mk(1, 0, 0, 0, 4'b0010, 32'hA5A5_A5A5, pass_w(32'h0)));

        // misaligned LW and LH
        setm(1, 0, 1, 3'b010, 5'd4, 32'h0000_0101, 32'h0, 0, 32'h0);
        step(mk(0, 0, 1, 0, 4'b0000, 32'h0, '0));
        setm(1, 0, 1, 3'b001, 5'd4, 32'h0000_0103, 32'h0, 0, 32'h0);
        step(mk(0, 0, 1, 0, 4'b0000, 32'h0, '0));

        // stray ack without a request
        setm(1, 0, 0, 3'b010, 5'd2, 32'h0000_0020, 32'h0, 1, 32'hFFFF_0000);
        step(mk(0, 0, 0, 0, 4'b0000, 32'h0, pass_w(32'h0)));

        // reserved mode 011: full lanes, LW data
        setm(1, 0, 1, 3'b011, 5'd3, 32'h0000_0102, 32'h0, 1, 32'h89AB_CDEF);
        step(mk(1, 0, 0, 0, 4'b1111, 32'h0, pass_w(32'h89AB_CDEF)));

        // timeout (TIMEOUT=4): issue + 3 wait cycles stalled, error in 4th wait cycle
        setm(1, 0, 1, 3'b010, 5'd9, 32'h0000_0200, 32'h0, 0, 32'h0);
        for (int i = 0; i < 4; i++)
            step(mk(1, 1, 0, 0, 4'b1111, 32'h0, '0));
        step(mk(1, 0, 0, 1, 4'b1111, 32'h0, '0));
        setm(1, 0, 0, 3'b000, 5'd3, 32'h0000_0044, 32'h0, 0, 32'h0);
        step(mk(0, 0, 0, 0, 4'b0000, 32'h0, pass_w(32'h0)));

        // reset while waiting, then a fresh LW
        setm(1, 0, 1, 3'b010, 5'd10, 32'h0000_0300, 32'h0, 0, 32'h0);
        step(mk(1, 1, 0, 0, 4'b1111, 32'h0, '0));
        step(mk(1, 1, 0, 0, 4'b1111, 32'h0, '0));
        rst = 1'b1;
        e = mk(0, 0, 0, 0, 4'b0000, 32'h0, '0);
        e.wnow0 = 1'b1;
        step(e);
        rst = 1'b0;
        setm(1, 0, 1, 3'b010, 5'd10, 32'h0000_0300, 32'h0, 1, 32'hCAFE_F00D);
        step(mk(1, 0, 0, 0, 4'b1111, 32'h0, pass_w(32'hCAFE_F00D)));

        setm(0, 0, 0, 3'b000, 5'd0, 32'h0, 32'h0, 0, 32'h0);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
